ex_operand_muldiv: RTL and testbench
====================================

# ex_operand_muldiv

Execute-stage datapath block of the 5-stage MIPS pipeline, directly downstream of the forwarding unit. It consumes `forward_a`/`forward_b` to select ALU operands from the ID/EX register, the EX/MEM result or the MEM/WB writeback value, and computes single-cycle ALU results. It also hosts an iterative signed multiply/divide unit with HI/LO registers. While that unit runs, it asserts a stall to the hazard/pipeline control.

## Interface
- `WIDTH`, 32, datapath width; HI/LO are each `WIDTH` bits.
- `clk_i` in 1: single clock; all state updates on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `valid_i` in 1: a valid instruction occupies EX.
- `alu_op_i` in 4: opcode. 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1000 MULT, 1001 DIV, 1010 MFHI, 1011 MFLO. Others return 0.
- `forward_a` in 2: operand A source. 00 `rs_data_i`, 01 `mem_fwd_i`, 10 `wb_fwd_i`, 11 treated as 00.
- `forward_b` in 2: operand B source, same encoding, applied to `rt_data_i`.
- `rs_data_i`, `rt_data_i` in WIDTH: register file values from ID/EX.
- `mem_fwd_i` in WIDTH: EX/MEM ALU result.
- `wb_fwd_i` in WIDTH: MEM/WB writeback data.
- `alu_src_i` in 1: 1 selects `imm_i` as operand B. The forwarded rt value is still used for `store_data_o`.
- `imm_i` in WIDTH: sign-extended immediate.
- `result_o` out WIDTH: ALU result to EX/MEM.
- `store_data_o` out WIDTH: forwarded rt value for stores.
- `zero_o` out 1: `result_o == 0`.
- `stall_o` out 1: hold IF/ID/EX; EX instruction must not advance.
- `hi_o`, `lo_o` out WIDTH: architectural HI/LO.

## Operation
- Operand mux: combinational. A = fwd(A), Bf = fwd(B), B = `alu_src_i` ? `imm_i` : Bf. `store_data_o` = Bf.
- ADD/SUB wrap modulo 2^WIDTH; no overflow trap.
- SLT is signed and yields 1 or 0.
- MFHI/MFLO return `hi_o`/`lo_o`.
- MULT/DIV return 0 on `result_o`.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE to MUL/DIV when `valid_i` and op ∈ {MULT, DIV}. On that edge, capture |A|, |B|, both sign bits and the op, and clear the 6-bit iteration counter.
  - MUL: shift-add, one bit per cycle, on unsigned magnitudes.
  - DIV: restoring division, one quotient bit per cycle.
  - After 32 iterations: apply sign fix-up, write HI/LO, enter DONE.
  - DONE to IDLE unconditionally.
- MULT: {HI,LO} = signed 64-bit product A×B.
- DIV: LO = quotient truncated toward zero; HI = remainder carrying the sign of the dividend.
- DIV by zero: HI = dividend A, LO = all ones. Takes the same number of cycles as a normal divide.
- Operands are captured at issue only. Changes on `mem_fwd_i`/`wb_fwd_i`/`rs_data_i` during the stall do not affect the result, since downstream stages keep draining.
- `stall_o` = !`rst_i` && ((IDLE && `valid_i` && op ∈ {MULT, DIV}) || MUL || DIV). It is low in DONE, so the stalled instruction leaves EX at the end of DONE without re-triggering.

## Timing
- ALU ops: 0-cycle latency, combinational from inputs to `result_o`/`zero_o`/`store_data_o`.
- MULT/DIV:
  - Issue cycle C0: `stall_o` = 1.
  - Iterations occupy C1..C32 with `stall_o` = 1.
  - HI/LO are written at the end of C32.
  - C33 is DONE with `stall_o` = 0.
  - Total `stall_o` high: 33 cycles.
- An MFHI/MFLO entering EX at C34 (the next instruction) sees the new HI/LO. No extra interlock is needed.
- HI/LO change only at the end of the last iteration cycle; intermediate values are never visible.
- Reset values: state IDLE, counter 0, `hi_o` = `lo_o` = 0, `stall_o` = 0.
- `rst_i` asserted mid-MUL/DIV aborts the operation. HI/LO clear to 0, the FSM is in IDLE on the next cycle, and `stall_o` is 0 during the reset cycle.
- `valid_i` = 0 in IDLE: no state change. `valid_i` is ignored in MUL, DIV and DONE.

## Test plan
- Forwarding mux: `rs_data_i`=1, `mem_fwd_i`=2, `wb_fwd_i`=3, ADD, B=`rt_data_i`=10. Cycle `forward_a` through 00/01/10/11 -> `result_o` = 11, 12, 13, 11. Repeat with `forward_b`, and check `store_data_o` tracks Bf when `alu_src_i`=1.
- ALU ops: SLT A=0xFFFFFFFF, B=1 -> 1. SUB 5-5 -> 0 with `zero_o`=1. NOR 0,0 -> 0xFFFFFFFF. ADD 0x7FFFFFFF+1 -> 0x80000000.
- MULT: A=-3, B=7 -> `stall_o` high exactly 33 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB. Following MFLO returns 0xFFFFFFEB.
- DIV: -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. 7/0 -> HI=7, LO=0xFFFFFFFF, 33 stall cycles.
- Operand capture: start MULT 6×7, then toggle `mem_fwd_i` and `forward_a` during the stall -> LO=42, HI=0.
- Reset mid-op: assert `rst_i` at iteration 10 of a DIV -> next cycle `stall_o`=0 and HI=LO=0. A fresh MULT 2×3 afterwards yields LO=6.

Source files
------------

// File: rtl/ex_operand_muldiv.sv
// Execute-stage operand forwarding mux, single-cycle ALU and iterative signed MULT/DIV unit with HI/LO.
// Latency: ALU ops are combinational; MULT/DIV hold the stall for 33 cycles and write HI/LO after 32 iterations.
// Backpressure: stall_o holds IF/ID/EX while the multiply/divide runs; it drops in DONE so the op retires once.
module ex_operand_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [3:0]       alu_op_i,
  input  logic [1:0]       forward_a,
  input  logic [1:0]       forward_b,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  input  logic [WIDTH-1:0] mem_fwd_i,
  input  logic [WIDTH-1:0] wb_fwd_i,
  input  logic             alu_src_i,
  input  logic [WIDTH-1:0] imm_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] store_data_o,
  output logic             zero_o,
  output logic             stall_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;
  localparam logic [3:0] OP_MFHI = 4'b1010;
  localparam logic [3:0] OP_MFLO = 4'b1011;

  localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t             state;
  logic [5:0]         cnt;
  // MUL: {partial product, remaining multiplier}; DIV: {remainder, remaining dividend / quotient}
  logic [2*WIDTH-1:0] acc;
  // MUL: multiplicand magnitude; DIV: divisor magnitude
  logic [WIDTH-1:0]   mag_op;
  logic               sign_a;
  logic               sign_b;
  logic               div_zero;

  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_bf;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               is_md;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   div_quo;
  logic [WIDTH-1:0]   div_rem;
  logic [WIDTH-1:0]   div_lo;
  logic [WIDTH-1:0]   div_hi;

  // Operand selection: forwarding for A and B, then immediate override for B only
  always_comb begin
    case (forward_a)
      2'b01:   op_a = mem_fwd_i;
      2'b10:   op_a = wb_fwd_i;
      default: op_a = rs_data_i;
    endcase
    case (forward_b)
      2'b01:   op_bf = mem_fwd_i;
      2'b10:   op_bf = wb_fwd_i;
      default: op_bf = rt_data_i;
    endcase
    op_b  = alu_src_i ? imm_i : op_bf;
    mag_a = op_a[WIDTH-1] ? -op_a : op_a;
    mag_b = op_b[WIDTH-1] ? -op_b : op_b;
    is_md = (alu_op_i == OP_MULT) || (alu_op_i == OP_DIV);
  end

  assign store_data_o = op_bf;

  // Single-cycle ALU; MULT/DIV drive 0 and unknown opcodes return 0
  always_comb begin
    result_o = '0;
    case (alu_op_i)
      OP_AND:  result_o = op_a & op_b;
      OP_OR:   result_o = op_a | op_b;
      OP_ADD:  result_o = op_a + op_b;
      OP_SUB:  result_o = op_a - op_b;
      OP_SLT:  result_o = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_NOR:  result_o = ~(op_a | op_b);
      OP_MFHI: result_o = hi_o;
      OP_MFLO: result_o = lo_o;
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

  // One iteration of shift-add multiply and restoring divide, plus the final sign fix-up
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_op} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    mul_prod  = (sign_a ^ sign_b) ? -mul_next : mul_next;

    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_trial = div_shift - {1'b0, mag_op};
    if (div_trial[WIDTH]) begin
      div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
    div_quo = div_next[WIDTH-1:0];
    div_rem = div_next[2*WIDTH-1:WIDTH];
    // A zero divisor never fails the trial subtract, so the remainder ends as |A| and
    // the sign fix-up returns A itself; only the quotient needs overriding.
    div_lo  = div_zero ? '1 : ((sign_a ^ sign_b) ? -div_quo : div_quo);
    div_hi  = sign_a ? -div_rem : div_rem;
  end

  assign stall_o = !rst_i && (((state == IDLE) && valid_i && is_md) ||
                              (state == MUL) || (state == DIV));

  // Multiply/divide sequencer: capture magnitudes at issue, iterate 32 times, commit HI/LO once
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      mag_op   <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      hi_o     <= '0;
      lo_o     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i && is_md) begin
            cnt      <= '0;
            sign_a   <= op_a[WIDTH-1];
            sign_b   <= op_b[WIDTH-1];
            div_zero <= (op_b == '0);
            if (alu_op_i == OP_MULT) begin
              state  <= MUL;
              acc    <= {{WIDTH{1'b0}}, mag_b};
              mag_op <= mag_a;
            end else begin
              state  <= DIV;
              acc    <= {{WIDTH{1'b0}}, mag_a};
              mag_op <= mag_b;
            end
          end
        end
        MUL: begin
          acc <= mul_next;
          cnt <= cnt + 6'd1;
          if (cnt == LAST_ITER) begin
            {hi_o, lo_o} <= mul_prod;
            state        <= DONE;
          end
        end
        DIV: begin
          acc <= div_next;
          cnt <= cnt + 6'd1;
          if (cnt == LAST_ITER) begin
            hi_o  <= div_hi;
            lo_o  <= div_lo;
            state <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_operand_muldiv.sv
// Directed bench for ex_operand_muldiv: forwarding mux, ALU ops, MULT/DIV results and stall length, reset abort.
// Latency: combinational checks settle #1 after input change; multi-cycle ops sampled #1 after each rising edge.
// Backpressure: the bench holds the MULT/DIV instruction on the inputs while stall is high.
module tb_ex_operand_muldiv;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;
  localparam logic [3:0] OP_MFHI = 4'b1010;
  localparam logic [3:0] OP_MFLO = 4'b1011;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [3:0]  alu_op;
  logic [1:0]  forward_a;
  logic [1:0]  forward_b;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] mem_fwd;
  logic [31:0] wb_fwd;
  logic        alu_src;
  logic [31:0] imm;
  logic [31:0] result;
  logic [31:0] store_data;
  logic        zero;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;
  int n;
  logic [31:0] exp_fa [4];
  logic [31:0] exp_fb [4];

  ex_operand_muldiv #(.WIDTH(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .valid_i      (valid),
    .alu_op_i     (alu_op),
    .forward_a    (forward_a),
    .forward_b    (forward_b),
    .rs_data_i    (rs_data),
    .rt_data_i    (rt_data),
    .mem_fwd_i    (mem_fwd),
    .wb_fwd_i     (wb_fwd),
    .alu_src_i    (alu_src),
    .imm_i        (imm),
    .result_o     (result),
    .store_data_o (store_data),
    .zero_o       (zero),
    .stall_o      (stall),
    .hi_o         (hi),
    .lo_o         (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a MULT/DIV and count stall cycles; returns sitting in the DONE cycle.
  task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, output int cnt);
    logic [31:0] hi0;
    logic [31:0] lo0;
    hi0       = hi;
    lo0       = lo;
    rs_data   = a;
    rt_data   = b;
    forward_a = 2'b00;
    forward_b = 2'b00;
    alu_src   = 1'b0;
    alu_op    = op;
    valid     = 1'b1;
    cnt       = 0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (!stall) break;
      cnt++;
      if (cnt == 17) begin
        chk_eq("hold_hi", hi, hi0);
        chk_eq("hold_lo", lo, lo0);
        chk_eq("md_result_zero", result, 32'h0);
      end
      if (disturb && cnt == 2) begin
        mem_fwd   = 32'd99;
        forward_a = 2'b01;
        rs_data   = 32'd5;
      end
      tick();
    end
    forward_a = 2'b00;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; alu_op = OP_AND;
    forward_a = 2'b00; forward_b = 2'b00;
    rs_data = '0; rt_data = '0; mem_fwd = '0; wb_fwd = '0;
    alu_src = 1'b0; imm = '0;
    tick();
    tick();
    chk_eq("rst_hi", hi, 32'h0);
    chk_eq("rst_lo", lo, 32'h0);
    chk_eq("rst_stall", {31'b0, stall}, 32'h0);
    rst = 1'b0;
    tick();

    // Forwarding mux, operand A then B
    exp_fa = '{32'd11, 32'd12, 32'd13, 32'd11};
    exp_fb = '{32'd11, 32'd3, 32'd4, 32'd11};
    rs_data = 32'd1; mem_fwd = 32'd2; wb_fwd = 32'd3; rt_data = 32'd10; alu_op = OP_ADD;
    for (int i = 0; i < 4; i++) begin
      forward_a = 2'(i);
      #1;
      chk_eq($sformatf("fwd_a_%0d", i), result, exp_fa[i]);
    end
    forward_a = 2'b00;
    for (int i = 0; i < 4; i++) begin
      forward_b = 2'(i);
      #1;
      chk_eq($sformatf("fwd_b_%0d", i), result, exp_fb[i]);
      chk_eq($sformatf("store_b_%0d", i), store_data, exp_fb[i] - 32'd1);
    end
    alu_src = 1'b1; imm = 32'd100; forward_b = 2'b01;
    #1;
    chk_eq("imm_result", result, 32'd101);
    chk_eq("imm_store", store_data, 32'd2);
    forward_b = 2'b10;
    #1;
    chk_eq("imm_store_wb", store_data, 32'd3);
    alu_src = 1'b0; forward_b = 2'b00;

    // ALU ops
    alu_op = OP_SLT; rs_data = 32'hFFFFFFFF; rt_data = 32'd1; #1;
    chk_eq("slt_neg", result, 32'd1);
    rs_data = 32'd1; rt_data = 32'hFFFFFFFF; #1;
    chk_eq("slt_pos", result, 32'd0);
    alu_op = OP_SUB; rs_data = 32'd5; rt_data = 32'd5; #1;
    chk_eq("sub_zero", result, 32'd0);
    chk_eq("sub_zero_flag", {31'b0, zero}, 32'd1);
    alu_op = OP_NOR; rs_data = 32'd0; rt_data = 32'd0; #1;
    chk_eq("nor", result, 32'hFFFFFFFF);
    chk_eq("nor_zero_flag", {31'b0, zero}, 32'd0);
    alu_op = OP_ADD; rs_data = 32'h7FFFFFFF; rt_data = 32'd1; #1;
    chk_eq("add_wrap", result, 32'h80000000);
    alu_op = OP_AND; rs_data = 32'hF0F0_1234; rt_data = 32'h0FF0_00FF; #1;
    chk_eq("and", result, 32'h00F0_0034);
    alu_op = OP_OR; #1;
    chk_eq("or", result, 32'hFFF0_12FF);
    alu_op = 4'b0011; #1;
    chk_eq("undef_op", result, 32'h0);
    chk_eq("alu_no_stall", {31'b0, stall}, 32'h0);
    tick();

    // MULT -3 x 7 and readback through MFLO/MFHI
    run_md(OP_MULT, 32'hFFFFFFFD, 32'd7, 1'b0, n);
    chk_eq("mult_stall_cycles", n, 32'd33);
    chk_eq("mult_hi", hi, 32'hFFFFFFFF);
    chk_eq("mult_lo", lo, 32'hFFFFFFEB);
    tick();
    alu_op = OP_MFLO; #1;
    chk_eq("mflo", result, 32'hFFFFFFEB);
    chk_eq("mflo_no_stall", {31'b0, stall}, 32'h0);
    alu_op = OP_MFHI; #1;
    chk_eq("mfhi", result, 32'hFFFFFFFF);
    tick();
    valid = 1'b0;
    tick();

    // MULT boundaries
    run_md(OP_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, n);
    chk_eq("mult_max_hi", hi, 32'h3FFFFFFF);
    chk_eq("mult_max_lo", lo, 32'h00000001);
    tick(); valid = 1'b0; tick();
    run_md(OP_MULT, 32'h80000000, 32'hFFFFFFFF, 1'b0, n);
    chk_eq("mult_min_hi", hi, 32'h00000000);
    chk_eq("mult_min_lo", lo, 32'h80000000);
    tick(); valid = 1'b0; tick();

    // DIV cases
    run_md(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, n);
    chk_eq("div_neg_cycles", n, 32'd33);
    chk_eq("div_neg_lo", lo, 32'hFFFFFFFD);
    chk_eq("div_neg_hi", hi, 32'hFFFFFFFF);
    tick(); valid = 1'b0; tick();
    run_md(OP_DIV, 32'd7, 32'hFFFFFFFE, 1'b0, n);
    chk_eq("div_negb_lo", lo, 32'hFFFFFFFD);
    chk_eq("div_negb_hi", hi, 32'h00000001);
    tick(); valid = 1'b0; tick();
    run_md(OP_DIV, 32'd7, 32'd0, 1'b0, n);
    chk_eq("div0_cycles", n, 32'd33);
    chk_eq("div0_hi", hi, 32'd7);
    chk_eq("div0_lo", lo, 32'hFFFFFFFF);
    tick(); valid = 1'b0; tick();

    // Operand capture: forwarding inputs change during the stall
    run_md(OP_MULT, 32'd6, 32'd7, 1'b1, n);
    chk_eq("capture_cycles", n, 32'd33);
    chk_eq("capture_lo", lo, 32'd42);
    chk_eq("capture_hi", hi, 32'd0);
    tick(); valid = 1'b0; tick();

    // Reset during a divide
    rs_data = 32'd100; rt_data = 32'd3; alu_op = OP_DIV; valid = 1'b1; #1;
    chk_eq("rdiv_issue_stall", {31'b0, stall}, 32'd1);
    for (int i = 0; i < 10; i++) tick();
    chk_eq("rdiv_mid_stall", {31'b0, stall}, 32'd1);
    rst = 1'b1; #1;
    chk_eq("rdiv_rst_stall", {31'b0, stall}, 32'd0);
    tick();
    rst = 1'b0; valid = 1'b0; #1;
    chk_eq("rdiv_after_stall", {31'b0, stall}, 32'd0);
    chk_eq("rdiv_after_hi", hi, 32'd0);
    chk_eq("rdiv_after_lo", lo, 32'd0);
    tick();
    chk_eq("rdiv_idle_stall", {31'b0, stall}, 32'd0);
    run_md(OP_MULT, 32'd2, 32'd3, 1'b0, n);
    chk_eq("post_rst_cycles", n, 32'd33);
    chk_eq("post_rst_lo", lo, 32'd6);
    chk_eq("post_rst_hi", hi, 32'd0);
    tick(); valid = 1'b0; tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
